// File: rtl/inst_mem_loader_if.sv
// Word handshake and byte-wide memory write bus for inst_mem_loader.
// master = word source / memory side, slave = the loader itself.
interface inst_mem_loader_if;
  logic        Word_Valid;
  logic [31:0] Word_Data;
  logic        Word_Ready;
  logic        Mem_Write_En;
  logic [63:0] Mem_Write_Address;
  logic [7:0]  Mem_Write_Data;

  modport master (
    output Word_Valid, Word_Data,
    input  Word_Ready, Mem_Write_En, Mem_Write_Address, Mem_Write_Data
  );

  modport slave (
    input  Word_Valid, Word_Data,
    output Word_Ready, Mem_Write_En, Mem_Write_Address, Mem_Write_Data
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Serializes 32-bit instruction words into four little-endian byte writes at an
// auto-incrementing address. Optional running XOR checksum: INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          MEM_BYTES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  inst_mem_loader_if.slave   bus,
  output logic [63:0]        Load_Address,
  output logic               Full
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]         Checksum
`endif
);

  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t      state_q;
  logic [1:0]  byteIdx_q;
  logic [31:0] word_q;
  logic [63:0] loadAddr_q;
  logic        memEn_q;
  logic [63:0] memAddr_q;
  logic [7:0]  memData_q;
  logic        full_q;

  logic [1:0]  byteIdx_d;
  logic [63:0] loadAddr_d;

  assign byteIdx_d  = byteIdx_q + 2'd1;
  assign loadAddr_d = loadAddr_q + 64'd4;

  // Memory-side outputs are registered one step ahead so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byteIdx_q  <= 2'd0;
      word_q     <= 32'd0;
      loadAddr_q <= BASE_ADDR;
      memEn_q    <= 1'b0;
      memAddr_q  <= BASE_ADDR;
      memData_q  <= 8'd0;
      full_q     <= 1'b0;
    end else if (Start) begin
      state_q    <= IDLE;
      byteIdx_q  <= 2'd0;
      loadAddr_q <= BASE_ADDR;
      memEn_q    <= 1'b0;
      memAddr_q  <= BASE_ADDR;
      memData_q  <= 8'd0;
      full_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Word_Valid) begin
            state_q   <= WRITE;
            byteIdx_q <= 2'd0;
            word_q    <= bus.Word_Data;
            memEn_q   <= 1'b1;
            memAddr_q <= loadAddr_q;
            memData_q <= bus.Word_Data[7:0];
          end
        end
        WRITE: begin
          if (byteIdx_q == 2'd3) begin
            byteIdx_q  <= 2'd0;
            loadAddr_q <= loadAddr_d;
            memEn_q    <= 1'b0;
            memAddr_q  <= loadAddr_d;
            memData_q  <= 8'd0;
            if (loadAddr_d == END_ADDR) begin
              state_q <= FULL;
              full_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            byteIdx_q <= byteIdx_d;
            memAddr_q <= loadAddr_q + 64'(byteIdx_d);
            memData_q <= word_q[{byteIdx_d, 3'b000} +: 8];
          end
        end
        FULL: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Word_Ready        = (state_q == IDLE) && !Start;
  assign bus.Mem_Write_En      = memEn_q;
  assign bus.Mem_Write_Address = memAddr_q;
  assign bus.Mem_Write_Data    = memData_q;
  assign Load_Address          = loadAddr_q;
  assign Full                  = full_q;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q;

  // Each byte is folded in on the edge that ends its strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= 8'd0;
    end else if (Start) begin
      checksum_q <= 8'd0;
    end else if (memEn_q) begin
      checksum_q <= checksum_q ^ memData_q;
    end
  end

  assign Checksum = checksum_q;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: queue-based reference model compared
// every cycle, plus hand-computed literal expectations for each directed scenario.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [63:0] Load_Address;
  logic        Full;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]  Checksum;
`endif

  inst_mem_loader_if bus();

  inst_mem_loader #(.BASE_ADDR(64'd0), .MEM_BYTES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .bus          (bus),
    .Load_Address (Load_Address),
    .Full         (Full)
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    ,
    .Checksum     (Checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a word becomes four queued byte writes; one leaves per edge.
  localparam logic [63:0] MBASE = 64'd0;
  localparam logic [63:0] MEND  = 64'd16;
  logic [63:0] mLoad;
  logic        mFull;
  logic [7:0]  mChk;
  logic [63:0] qAddr[$];
  logic [7:0]  qData[$];

  always @(posedge clk or posedge reset) begin
    if (reset || Start) begin
      qAddr.delete();
      qData.delete();
      mLoad = MBASE;
      mFull = 1'b0;
      mChk  = 8'd0;
    end else if (qAddr.size() != 0) begin
      mChk = mChk ^ qData[0];
      void'(qAddr.pop_front());
      void'(qData.pop_front());
      if (qAddr.size() == 0) begin
        mLoad = mLoad + 64'd4;
        if (mLoad == MEND) mFull = 1'b1;
      end
    end else if (!mFull && bus.Word_Valid) begin
      for (int i = 0; i < 4; i++) begin
        qAddr.push_back(mLoad + 64'(i));
        qData.push_back(bus.Word_Data[8*i +: 8]);
      end
    end
  end

  bit          checkEn = 1'b0;
  logic        expEn;
  int          readyLow = 0;
  int          strobeCnt = 0;
  logic        pendEn = 1'b0;
  logic [63:0] pendA;
  logic [7:0]  pendD;
  logic [7:0]  benchMem [16];

  always @(negedge clk) begin
    if (checkEn) begin
      expEn = (qAddr.size() != 0);
      checkOutput("Mem_Write_En", 64'(bus.Mem_Write_En), 64'(expEn));
      checkOutput("Mem_Write_Address", bus.Mem_Write_Address, expEn ? qAddr[0] : mLoad);
      checkOutput("Mem_Write_Data", 64'(bus.Mem_Write_Data), expEn ? 64'(qData[0]) : 64'd0);
      checkOutput("Word_Ready", 64'(bus.Word_Ready), 64'(!expEn && !mFull && !Start));
      checkOutput("Full", 64'(Full), 64'(mFull));
      checkOutput("Load_Address", Load_Address, mLoad);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      checkOutput("Checksum", 64'(Checksum), 64'(mChk));
`endif
      if (bus.Word_Ready === 1'b0) readyLow++;
      if (bus.Mem_Write_En === 1'b1) strobeCnt++;
    end
    pendEn = (bus.Mem_Write_En === 1'b1);
    pendA  = bus.Mem_Write_Address;
    pendD  = bus.Mem_Write_Data;
  end

  always @(posedge clk) begin
    if (pendEn && !reset && pendA < 64'd16) benchMem[pendA[3:0]] = pendD;
  end

  task automatic applyStimulus(input logic s, input logic v, input logic [31:0] d);
    @(negedge clk);
    #1;
    Start          = s;
    bus.Word_Valid = v;
    bus.Word_Data  = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 reset = 1'b1;
    Start = 1'b0;
    bus.Word_Valid = 1'b0;
    bus.Word_Data = 32'd0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  logic [31:0] words [4] = '{32'h0F053483, 32'h009A84B3, 32'h00148493, 32'h0E953823};
  logic [7:0]  fullImg [16] = '{8'h83, 8'h34, 8'h05, 8'h0F, 8'hB3, 8'h84, 8'h9A, 8'h00,
                                8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h38, 8'h95, 8'h0E};

  initial begin
    for (int i = 0; i < 16; i++) benchMem[i] = 8'd0;
    reset = 1'b1;
    Start = 1'b0;
    bus.Word_Valid = 1'b0;
    bus.Word_Data = 32'd0;
    #1 checkEn = 1'b1;

    // Reset values and a single word
    doReset();
    checkOutput("reset Full", 64'(Full), 64'd0);
    checkOutput("reset Load_Address", Load_Address, 64'd0);
    checkOutput("reset Mem_Write_En", 64'(bus.Mem_Write_En), 64'd0);
    checkOutput("reset Word_Ready", 64'(bus.Word_Ready), 64'd1);
    readyLow = 0;
    applyStimulus(1'b0, 1'b1, words[0]);
    repeat (7) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("w0 Load_Address", Load_Address, 64'd4);
    checkOutput("w0 ready-low cycles", 64'(readyLow), 64'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("w0 mem[%0d]", i), 64'(benchMem[i]), 64'(fullImg[i]));
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    checkOutput("w0 Checksum", 64'(Checksum), 64'hBD);
`endif

    // Fill to capacity with Word_Valid held high, then offer a fifth word
    doReset();
    for (int w = 0; w < 4; w++) repeat (5) applyStimulus(1'b0, 1'b1, words[w]);
    repeat (10) applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("fill Full", 64'(Full), 64'd1);
    checkOutput("fill Word_Ready", 64'(bus.Word_Ready), 64'd0);
    checkOutput("fill Load_Address", Load_Address, 64'd16);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("fill mem[%0d]", i), 64'(benchMem[i]), 64'(fullImg[i]));

    // Start out of FULL, then Start again after byte 1 of a word
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("restart Full", 64'(Full), 64'd0);
    checkOutput("restart Load_Address", Load_Address, 64'd0);
    strobeCnt = 0;
    applyStimulus(1'b0, 1'b1, words[1]);
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("abort strobes", 64'(strobeCnt), 64'd2);
    checkOutput("abort Load_Address", Load_Address, 64'd0);
    checkOutput("abort Full", 64'(Full), 64'd0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    checkOutput("abort Checksum", 64'(Checksum), 64'h00);
`endif
    applyStimulus(1'b0, 1'b1, words[2]);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("after-abort Load_Address", Load_Address, 64'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("after-abort mem[%0d]", i), 64'(benchMem[i]), 64'(fullImg[8 + i]));

    // Start and Word_Valid together: rejected; Word_Valid alone next cycle: accepted
    applyStimulus(1'b1, 1'b1, words[3]);
    applyStimulus(1'b0, 1'b1, words[3]);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("start+valid Load_Address", Load_Address, 64'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("start+valid mem[%0d]", i), 64'(benchMem[i]), 64'(fullImg[12 + i]));

    // Asynchronous reset while byte 2 is on the bus
    applyStimulus(1'b0, 1'b1, words[0]);
    applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async Mem_Write_En", 64'(bus.Mem_Write_En), 64'd0);
    checkOutput("async Mem_Write_Address", bus.Mem_Write_Address, 64'd0);
    checkOutput("async Mem_Write_Data", 64'(bus.Mem_Write_Data), 64'd0);
    checkOutput("async Load_Address", Load_Address, 64'd0);
    checkOutput("async Full", 64'(Full), 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b0, 1'b1, words[1]);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("post-reset Load_Address", Load_Address, 64'd4);
    checkOutput("post-reset mem[2]", 64'(benchMem[2]), 64'h9A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Write-side companion to the byte-wide instruction memory. Accepts 32-bit instruction words over a valid/ready handshake and serializes each word into four consecutive byte writes, in little-endian order, at an auto-incrementing byte address. It sits between the boot/test program source and the instruction memory write port. The fetch side assembles the instruction at address A from bytes A..A+3 (byte A = bits [7:0]), and this block produces exactly that layout.

## Interface
Parameters:
- BASE_ADDR, 0, byte address of the first byte written after reset or Start.
- MEM_BYTES, 16, memory capacity in bytes; must be a multiple of 4 and at least 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  synchronous restart: pointer back to BASE_ADDR, any in-flight word aborted.
- Word_Valid  in  1  Word_Data is valid.
- Word_Data  in  32  instruction word to store.
- Word_Ready  out  1  block can accept a word this cycle.
- Mem_Write_En  out  1  byte write strobe to instruction memory.
- Mem_Write_Address  out  64  byte address of the current write.
- Mem_Write_Data  out  8  byte being written.
- Load_Address  out  64  byte address where the next accepted word's byte 0 will go.
- Full  out  1  capacity reached; no further words accepted.

## Operation
- FSM states: IDLE, WRITE, FULL. WRITE holds a 2-bit byte index k (0..3) and a 32-bit word register.
- Word_Ready = (state == IDLE) && !Start. Combinational; it does not depend on Word_Valid.
- Word acceptance: Word_Valid && Word_Ready at a rising edge. Word_Data is latched, k is set to 0, and the FSM moves to WRITE.
- WRITE, each cycle:
  - Mem_Write_En = 1.
  - Mem_Write_Address = Load_Address + k.
  - Mem_Write_Data = word[8k+7:8k].
  - k increments at the edge.
- After k = 3, Load_Address advances by 4.
  - If the new value equals BASE_ADDR + MEM_BYTES, the next state is FULL.
  - Otherwise the next state is IDLE.
- FULL: Full = 1 and Word_Ready = 0. The block stays in FULL until reset or Start.
- Start, sampled at an edge in any state, takes priority over everything:
  - state goes to IDLE and k to 0;
  - Load_Address goes to BASE_ADDR;
  - Full goes to 0;
  - a partially written word is abandoned, and bytes already written stay in memory.
- Start and Word_Valid in the same cycle: the word is not accepted, because Word_Ready is 0.
- Address arithmetic is 64-bit unsigned. Load_Address never exceeds BASE_ADDR + MEM_BYTES, so there is no wrap.
- In IDLE and FULL: Mem_Write_En = 0, Mem_Write_Address = Load_Address, Mem_Write_Data = 0.

## Timing
- Reset values:
  - state IDLE, k = 0;
  - Load_Address = BASE_ADDR;
  - Full = 0, Mem_Write_En = 0;
  - Mem_Write_Address = BASE_ADDR, Mem_Write_Data = 0;
  - Word_Ready = 1 once reset is deasserted (when Start = 0).
- Asserting reset mid-WRITE forces Mem_Write_En = 0 immediately, without waiting for a clock edge.
- Latency, for a word accepted at edge N:
  - bytes 0..3 are driven in the cycles following edges N, N+1, N+2, N+3;
  - Word_Ready returns to 1 after edge N+4.
- Throughput: one word per 5 cycles.
- The memory captures each byte on the edge that ends its strobe cycle.
- All outputs except Word_Ready are registered or decode registered state only.

## Configuration
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - adds output port Checksum (out, 8 bits): running XOR of every byte written with Mem_Write_En = 1;
  - Checksum resets to 0 on reset and on Start;
  - each written byte is folded in at the edge that ends its strobe cycle.
- Undefined: the Checksum port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then one word 0x0F053483 with BASE_ADDR = 0:
  - writes 0x83@0, 0x34@1, 0x05@2, 0x0F@3 on four consecutive strobes;
  - Load_Address = 4 afterwards;
  - Word_Ready = 0 for exactly 4 cycles.
- Word_Valid held high with 0x0F053483, 0x009A84B3, 0x00148493, 0x0E953823:
  - 16 byte writes to addresses 0..15 with matching bytes;
  - Full = 1 and Word_Ready = 0 afterwards;
  - a fifth word is never accepted.
- Start pulsed after byte 1 of a word:
  - no further strobes;
  - Load_Address = 0, Full = 0;
  - the next word writes addresses 0..3.
- Start and Word_Valid asserted together in IDLE: no acceptance and no strobe; Word_Valid alone on the next cycle is accepted.
- Asynchronous reset asserted mid-cycle during byte 2: Mem_Write_En falls immediately; all outputs take their reset values before the next edge.
- With INST_MEM_LOADER_CHECKSUM_EN defined, after word 0x0F053483: Checksum = 0x83^0x34^0x05^0x0F = 0xBD. Start clears it to 0x00.
